mem_lsu: RTL

- Parametrised successor to the flat word memory used by the core: a byte-addressable, little-endian data memory with a load/store front end.
- Supports byte, half-word and word accesses, with sign or zero extension on loads.
- Request/response handshake with a configurable access latency.
- Reports range and size errors.
- Sits between the core's load/store stage and on-chip RAM; the behavioural test memory is replaced by this block.

---
 rtl/mem_lsu_if.sv | 26 ++
 rtl/mem_lsu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_if.sv
// Load/store request/response bundle between the core's LSU stage and mem_lsu.
interface mem_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rw;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;

  modport master (
    output req_valid, req_rw, req_size, req_unsigned, req_addr, req_data,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_rw, req_size, req_unsigned, req_addr, req_data,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_lsu.sv
// Byte-addressable little-endian data memory with a latency-configurable load/store front end.
// Define MEM_LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them down.
module mem_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned SIZE       = 256,
  parameter int unsigned LATENCY    = 1
) (
  input  logic     sys_clk,
  input  logic     sys_rst,
  mem_lsu_if.slave lsu
);
  localparam int unsigned NumBytes = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned IdxW     = $clog2(SIZE);
  localparam int unsigned AddrW1   = ADDR_WIDTH + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [BYTE_WIDTH-1:0] mem [SIZE];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_q;
  logic                  rw_q, uns_q, err_q;
  logic [3:0]            nb_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  resp_valid_q, resp_err_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  logic                  accept, from_idle, commit;
  logic [3:0]            acc_nb, acc_mask;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [AddrW1-1:0]     acc_last;
  logic                  acc_err;

  logic                  cm_rw, cm_uns, cm_err;
  logic [3:0]            cm_nb;
  logic [IdxW-1:0]       cm_idx;
  logic [DATA_WIDTH-1:0] cm_wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  sign;

  assign accept    = lsu.req_valid && ready_q;
  assign from_idle = (state_q == StIdle);
  // With zero latency the commit edge is the accept edge, so it must use the live request.
  assign commit    = (from_idle && accept && (LATENCY == 0)) ||
                     ((state_q == StWait) && (cnt_q == 4'd0));

  always_comb begin
    acc_nb   = 4'd1 << lsu.req_size;
    acc_mask = acc_nb - 4'd1;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    acc_addr = lsu.req_addr;
    acc_err  = (lsu.req_addr[3:0] & acc_mask) != 4'd0;
`else
    acc_addr = lsu.req_addr & ~ADDR_WIDTH'(acc_mask);
    acc_err  = 1'b0;
`endif
    // One extra bit so an access near the top of the address space cannot wrap past the check.
    acc_last = {1'b0, acc_addr} + AddrW1'(acc_mask);
    if (32'(acc_nb) > NumBytes) acc_err = 1'b1;
    if (acc_last >= AddrW1'(SIZE)) acc_err = 1'b1;
  end

  always_comb begin
    if (from_idle) begin
      cm_rw    = lsu.req_rw;
      cm_uns   = lsu.req_unsigned;
      cm_err   = acc_err;
      cm_nb    = acc_nb;
      cm_idx   = acc_addr[IdxW-1:0];
      cm_wdata = lsu.req_data;
    end else begin
      cm_rw    = rw_q;
      cm_uns   = uns_q;
      cm_err   = err_q;
      cm_nb    = nb_q;
      cm_idx   = idx_q;
      cm_wdata = wdata_q;
    end
  end

  // Lanes fill in ascending order, so sign holds the msb of the top loaded byte by the time the
  // extension lanes are reached.
  always_comb begin
    rdata = '0;
    sign  = 1'b0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (4'(i) < cm_nb) begin
        rdata[i*BYTE_WIDTH +: BYTE_WIDTH] = mem[cm_idx + IdxW'(i)];
        sign = mem[cm_idx + IdxW'(i)][BYTE_WIDTH-1];
      end else begin
        rdata[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{sign & ~cm_uns}};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Storage is deliberately not reset.
  always_ff @(posedge sys_clk) begin
    if (commit && cm_rw && !cm_err) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (4'(i) < cm_nb) mem[cm_idx + IdxW'(i)] <= cm_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b0;
      rw_q         <= 1'b0;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      nb_q         <= 4'd0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= (state_d == StIdle);
      resp_valid_q <= commit;
      if (accept) begin
        rw_q    <= lsu.req_rw;
        uns_q   <= lsu.req_unsigned;
        err_q   <= acc_err;
        nb_q    <= acc_nb;
        idx_q   <= acc_addr[IdxW-1:0];
        wdata_q <= lsu.req_data;
      end
      if (commit) begin
        resp_err_q  <= cm_err;
        resp_data_q <= (cm_err || cm_rw) ? '0 : rdata;
      end
    end
  end

  assign lsu.req_ready  = ready_q;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_data  = resp_data_q;
  assign lsu.resp_err   = resp_err_q;
endmodule
